// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset control path.
// Opcode/funct fields, ALU ops, mux selects, FSM states, decode classes.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SW     = 6'h2b;

  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_ADDU   = 6'h21;
  localparam logic [5:0] FN_SUBU   = 6'h23;
  localparam logic [5:0] FN_SLT    = 6'h2a;

  localparam logic [4:0] RT_BLTZAL = 5'h10;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_ADDI  = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_PASSB = 3'b101;

  localparam logic       SRCA_PC   = 1'b0;
  localparam logic       SRCA_RS   = 1'b1;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] DST_RT    = 2'b00;
  localparam logic [1:0] DST_RD    = 2'b01;
  localparam logic [1:0] DST_RA    = 2'b10;

  localparam logic [1:0] WB_ALU    = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXEC    = 3'd2;
  localparam logic [2:0] S_MEM     = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;
  localparam logic [2:0] S_BRANCH  = 3'd5;
  localparam logic [2:0] S_JUMP    = 3'd6;
  localparam logic [2:0] S_TRAP    = 3'd7;

  localparam logic [3:0] C_ALU_R   = 4'd0;
  localparam logic [3:0] C_ALU_I   = 4'd1;
  localparam logic [3:0] C_LOAD    = 4'd2;
  localparam logic [3:0] C_STORE   = 4'd3;
  localparam logic [3:0] C_BEQ     = 4'd4;
  localparam logic [3:0] C_BLTZAL  = 4'd5;
  localparam logic [3:0] C_J       = 4'd6;
  localparam logic [3:0] C_JAL     = 4'd7;
  localparam logic [3:0] C_JR      = 4'd8;
  localparam logic [3:0] C_ILL     = 4'd9;

endpackage

// File: rtl/mc_decode.sv
// Combinational IR decode: instruction class plus the EXEC-state
// ALU op and B-operand select.
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [3:0]  cls_o,
  output logic [2:0]  alu_op_o,
  output logic [1:0]  srcb_o,
  output logic        is_byte_o,
  output logic        is_addi_o
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;
  logic       unused_fields;

  assign op = instr_i[31:26];
  assign rt = instr_i[20:16];
  assign fn = instr_i[5:0];
  assign unused_fields = ^{instr_i[25:21], instr_i[15:6]};

  always_comb begin
    cls_o     = C_ILL;
    alu_op_o  = ALU_ADD;
    srcb_o    = SRCB_IMM;
    is_byte_o = 1'b0;
    is_addi_o = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        srcb_o = SRCB_RT;
        unique case (fn)
          FN_ADDU: cls_o = C_ALU_R;
          FN_SUBU: begin
            cls_o    = C_ALU_R;
            alu_op_o = ALU_SUB;
          end
          FN_SLT: begin
            cls_o    = C_ALU_R;
            alu_op_o = ALU_SLT;
          end
          FN_JR:   cls_o = C_JR;
          default: ;
        endcase
      end
      OP_REGIMM: begin
        if (rt == RT_BLTZAL) cls_o = C_BLTZAL;
      end
      OP_J:   cls_o = C_J;
      OP_JAL: cls_o = C_JAL;
      OP_BEQ: cls_o = C_BEQ;
      OP_ADDI: begin
        cls_o     = C_ALU_I;
        alu_op_o  = ALU_ADDI;
        is_addi_o = 1'b1;
      end
      OP_ORI: begin
        cls_o    = C_ALU_I;
        alu_op_o = ALU_OR;
      end
      OP_LUI: begin
        cls_o    = C_ALU_I;
        alu_op_o = ALU_PASSB;
      end
      OP_LW: cls_o = C_LOAD;
      OP_LB: begin
        cls_o     = C_LOAD;
        is_byte_o = 1'b1;
      end
      OP_SW: cls_o = C_STORE;
      OP_SB: begin
        cls_o     = C_STORE;
        is_byte_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/exec/mem/wb over the
// shared ALU and drives all datapath enables and mux selects.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        overflow,
  input  logic        bltzal_sel,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_byte,
  output logic        pc_we,
  output logic        ir_we,
  output logic [2:0]  alu_ctr,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_sel,
  output logic [1:0]  pc_src,
  output logic        illegal
);

  logic [2:0] state_q, state_d, st;
  logic       ovf_q, ovf_d;
  logic [3:0] cls;
  logic [2:0] alu_op;
  logic [1:0] srcb;
  logic       is_byte;
  logic       is_addi;

  mc_decode u_dec (
    .instr_i   (instr),
    .cls_o     (cls),
    .alu_op_o  (alu_op),
    .srcb_o    (srcb),
    .is_byte_o (is_byte),
    .is_addi_o (is_addi)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (cls)
          C_ALU_R, C_ALU_I,
          C_LOAD, C_STORE:   state_d = S_EXEC;
          C_BEQ, C_BLTZAL:   state_d = S_BRANCH;
          C_J, C_JAL, C_JR:  state_d = S_JUMP;
          default:           state_d = S_TRAP;
        endcase
      end
      S_EXEC: begin
        ovf_d   = overflow;
        state_d = (cls == C_LOAD || cls == C_STORE) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (mem_ready) state_d = (cls == C_LOAD) ? S_WB : S_FETCH;
      end
      S_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default: state_d = S_TRAP;
    endcase
  end

  // While reset is held the outputs already look like a fresh FETCH.
  assign st = rst_n ? state_q : S_FETCH;

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_byte  = 1'b0;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    alu_ctr   = ALU_ADD;
    alu_src_a = SRCA_PC;
    alu_src_b = SRCB_RT;
    reg_we    = 1'b0;
    reg_dst   = DST_RT;
    wb_sel    = WB_ALU;
    pc_src    = PC_ALU;
    illegal   = 1'b0;
    unique case (st)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_we     = mem_ready & rst_n;
        pc_we     = mem_ready & rst_n;
      end
      S_DECODE: alu_src_b = SRCB_BR;
      S_EXEC: begin
        alu_src_a = SRCA_RS;
        alu_src_b = srcb;
        alu_ctr   = alu_op;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = (cls == C_STORE);
        mem_byte = is_byte;
      end
      S_WB: begin
        reg_we  = ~(is_addi & ovf_q);
        reg_dst = (cls == C_ALU_R) ? DST_RD : DST_RT;
        wb_sel  = (cls == C_LOAD) ? WB_MDR : WB_ALU;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS;
        pc_src    = PC_ALUOUT;
        if (cls == C_BEQ) begin
          alu_ctr = ALU_SUB;
          pc_we   = zero;
        end else begin
          pc_we   = bltzal_sel;
          reg_we  = 1'b1;
          reg_dst = DST_RA;
          wb_sel  = WB_PC;
        end
      end
      S_JUMP: begin
        pc_we  = 1'b1;
        pc_src = (cls == C_JR) ? PC_RS : PC_JUMP;
        if (cls == C_JAL) begin
          reg_we  = 1'b1;
          reg_dst = DST_RA;
          wb_sel  = WB_PC;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized check of mc_ctrl against a per-instruction phase model.
// Each instruction is expanded into its expected cycle-by-cycle phases.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  logic        overflow = 1'b0;
  logic        bltzal_sel = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_byte, pc_we, ir_we;
  logic [2:0]  alu_ctr;
  logic        alu_src_a;
  logic [1:0]  alu_src_b, reg_dst, wb_sel, pc_src;
  logic        reg_we, illegal;

  mc_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .zero       (zero),
    .overflow   (overflow),
    .bltzal_sel (bltzal_sel),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_byte   (mem_byte),
    .pc_we      (pc_we),
    .ir_we      (ir_we),
    .alu_ctr    (alu_ctr),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .wb_sel     (wb_sel),
    .pc_src     (pc_src),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  localparam int K_ADDU = 0, K_SUBU = 1, K_SLT = 2, K_JR = 3;
  localparam int K_ADDI = 4, K_ORI = 5, K_LUI = 6, K_LW = 7;
  localparam int K_LB = 8, K_SW = 9, K_SB = 10, K_BEQ = 11;
  localparam int K_BLTZAL = 12, K_J = 13, K_JAL = 14, K_ILL = 15;

  localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3;
  localparam int P_W = 4, P_B = 5, P_J = 6, P_T = 7;

  function automatic bit is_r(int k);
    return k == K_ADDU || k == K_SUBU || k == K_SLT;
  endfunction
  function automatic bit is_ld(int k);
    return k == K_LW || k == K_LB;
  endfunction
  function automatic bit is_st(int k);
    return k == K_SW || k == K_SB;
  endfunction

  function automatic logic [31:0] build(int k);
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] w;
    rs  = 5'($urandom);
    rt  = 5'($urandom);
    rd  = 5'($urandom);
    imm = 16'($urandom);
    tgt = 26'($urandom);
    w = '0;
    case (k)
      K_ADDU:   w = {6'h00, rs, rt, rd, 5'd0, 6'h21};
      K_SUBU:   w = {6'h00, rs, rt, rd, 5'd0, 6'h23};
      K_SLT:    w = {6'h00, rs, rt, rd, 5'd0, 6'h2a};
      K_JR:     w = {6'h00, rs, 15'd0, 6'h08};
      K_ADDI:   w = {6'h08, rs, rt, imm};
      K_ORI:    w = {6'h0d, rs, rt, imm};
      K_LUI:    w = {6'h0f, rs, rt, imm};
      K_LW:     w = {6'h23, rs, rt, imm};
      K_LB:     w = {6'h20, rs, rt, imm};
      K_SW:     w = {6'h2b, rs, rt, imm};
      K_SB:     w = {6'h28, rs, rt, imm};
      K_BEQ:    w = {6'h04, rs, rt, imm};
      K_BLTZAL: w = {6'h01, rs, 5'h10, imm};
      K_J:      w = {6'h02, tgt};
      K_JAL:    w = {6'h03, tgt};
      default: begin
        case ($urandom_range(0, 2))
          0:       w = {6'h3f, tgt};
          1:       w = {6'h00, rs, rt, rd, 5'd0, 6'h20};
          default: w = {6'h01, rs, 5'h00, imm};
        endcase
      end
    endcase
    return w;
  endfunction

  // {mem_req, mem_we, mem_byte, pc_we, ir_we, alu_ctr, alu_src_a,
  //  alu_src_b, reg_we, reg_dst, wb_sel, pc_src, illegal}
  function automatic logic [18:0] expv(int ph, int k, bit rdy,
                                       bit z, bit bs, bit ov);
    logic       mq, mw, mb, pw, iw, sa, rw, il;
    logic [2:0] ac;
    logic [1:0] sb, rd, ws, ps;
    {mq, mw, mb, pw, iw, sa, rw, il} = '0;
    {ac, sb, rd, ws, ps} = '0;
    case (ph)
      P_F: begin
        mq = 1; sb = 2'b01; iw = rdy; pw = rdy;
      end
      P_D: sb = 2'b11;
      P_E: begin
        sa = 1;
        case (k)
          K_ADDU: begin ac = 3'd0; sb = 2'b00; end
          K_SUBU: begin ac = 3'd1; sb = 2'b00; end
          K_SLT:  begin ac = 3'd4; sb = 2'b00; end
          K_ADDI: begin ac = 3'd3; sb = 2'b10; end
          K_ORI:  begin ac = 3'd2; sb = 2'b10; end
          K_LUI:  begin ac = 3'd5; sb = 2'b10; end
          default: begin ac = 3'd0; sb = 2'b10; end
        endcase
      end
      P_M: begin
        mq = 1; mw = is_st(k); mb = (k == K_LB || k == K_SB);
      end
      P_W: begin
        rw = !(k == K_ADDI && ov);
        rd = is_r(k) ? 2'b01 : 2'b00;
        ws = is_ld(k) ? 2'b01 : 2'b00;
      end
      P_B: begin
        sa = 1; ps = 2'b01;
        if (k == K_BEQ) begin
          ac = 3'd1; pw = z;
        end else begin
          pw = bs; rw = 1; rd = 2'b10; ws = 2'b10;
        end
      end
      P_J: begin
        pw = 1; ps = (k == K_JR) ? 2'b11 : 2'b10;
        if (k == K_JAL) begin
          rw = 1; rd = 2'b10; ws = 2'b10;
        end
      end
      default: il = 1;
    endcase
    return {mq, mw, mb, pw, iw, ac, sa, sb, rw, rd, ws, ps, il};
  endfunction

  logic [18:0] obs;
  assign obs = {mem_req, mem_we, mem_byte, pc_we, ir_we, alu_ctr,
                alu_src_a, alu_src_b, reg_we, reg_dst, wb_sel,
                pc_src, illegal};

  // Called just after a rising edge; holds reset for one edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    chk({tag, " in-reset"}, 32'(obs), 32'(expv(P_F, 0, 0, 0, 0, 0)));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run(input int k, input int fw, input int mw,
                     input bit z, input bit ov, input bit bs,
                     input int rst_at);
    int ph[$];
    bit rd[$];
    logic [31:0] w;
    w = build(k);
    for (int i = 0; i < fw; i++) begin
      ph.push_back(P_F); rd.push_back(1'b0);
    end
    ph.push_back(P_F); rd.push_back(1'b1);
    ph.push_back(P_D); rd.push_back(1'($urandom));
    if (k == K_ILL) begin
      for (int i = 0; i < 11; i++) begin
        ph.push_back(P_T); rd.push_back(1'($urandom));
      end
    end else if (k == K_BEQ || k == K_BLTZAL) begin
      ph.push_back(P_B); rd.push_back(1'($urandom));
    end else if (k == K_J || k == K_JAL || k == K_JR) begin
      ph.push_back(P_J); rd.push_back(1'($urandom));
    end else begin
      ph.push_back(P_E); rd.push_back(1'($urandom));
      if (is_ld(k) || is_st(k)) begin
        for (int i = 0; i < mw; i++) begin
          ph.push_back(P_M); rd.push_back(1'b0);
        end
        ph.push_back(P_M); rd.push_back(1'b1);
      end
      if (!is_st(k)) begin
        ph.push_back(P_W); rd.push_back(1'($urandom));
      end
    end
    for (int i = 0; i < ph.size(); i++) begin
      if (i == rst_at) begin
        do_reset($sformatf("k%0d mid-reset", k));
        return;
      end
      instr = w;
      zero = z;
      overflow = ov;
      bltzal_sel = bs;
      mem_ready = rd[i];
      @(negedge clk);
      chk($sformatf("k%0d ph%0d c%0d", k, ph[i], i),
          32'(obs), 32'(expv(ph[i], k, rd[i], z, bs, ov)));
      @(posedge clk);
      #1;
    end
    if (k == K_ILL) do_reset("trap");
  endtask

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("por");
    run(K_ADDU, 0, 0, 0, 0, 0, -1);
    run(K_LW, 0, 2, 0, 0, 0, -1);
    run(K_ADDI, 0, 0, 0, 1, 0, -1);
    run(K_ADDU, 0, 0, 0, 0, 0, -1);
    run(K_BEQ, 0, 0, 0, 0, 0, -1);
    run(K_BEQ, 1, 0, 1, 0, 0, -1);
    run(K_BLTZAL, 0, 0, 0, 0, 0, -1);
    run(K_BLTZAL, 0, 0, 1, 0, 1, -1);
    run(K_SW, 0, 3, 0, 0, 0, 4);
    run(K_SB, 0, 0, 0, 0, 0, -1);
    run(K_ILL, 0, 0, 0, 0, 0, -1);
    run(K_JAL, 0, 0, 0, 0, 0, -1);
    for (int n = 0; n < 300; n++) begin
      run($urandom_range(0, 14), $urandom_range(0, 3),
          $urandom_range(0, 3), 1'($urandom), 1'($urandom),
          1'($urandom), -1);
    end
    for (int n = 0; n < 4; n++) begin
      run(K_ILL, $urandom_range(0, 2), 0, 0, 0, 0, -1);
      run(K_LB, 0, $urandom_range(0, 2), 0, 0, 0, -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
